// File: rtl/mdio_phy_responder_if.sv
// Register strobe bus between the MDIO responder and a local register file.
// master: responder side (addr/strobes/wdata out, rdata in); slave: register file.
interface mdio_phy_responder_if;
  logic [4:0]  reg_addr;
  logic        reg_rd_en;
  logic [15:0] reg_rdata;
  logic        reg_wr_en;
  logic [15:0] reg_wdata;

  modport master (
    output reg_addr,
    output reg_rd_en,
    input  reg_rdata,
    output reg_wr_en,
    output reg_wdata
  );

  modport slave (
    input  reg_addr,
    input  reg_rd_en,
    output reg_rdata,
    input  reg_wr_en,
    input  reg_wdata
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder: decodes frames for PHY_ADDR, drives read data.
// Ports: clk, reset_n (sync, active-low), mdc, mdio_in, mdio_out, mdio_oen, frame_err, regs.
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mdc,
  input  logic mdio_in,
  output logic mdio_out,
  output logic mdio_oen,
  output logic frame_err,
  mdio_phy_responder_if.master regs
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] ST1   = 4'd1;
  localparam logic [3:0] OP    = 4'd2;
  localparam logic [3:0] PHYAD = 4'd3;
  localparam logic [3:0] REGAD = 4'd4;
  localparam logic [3:0] TA_RD = 4'd5;
  localparam logic [3:0] RDATA = 4'd6;
  localparam logic [3:0] TA_WR = 4'd7;
  localparam logic [3:0] WDATA = 4'd8;

  localparam logic [5:0] PRE = 6'(PREAMBLE_LEN);

  logic [1:0]  mdc_s;
  logic [1:0]  mdi_s;
  logic        mdc_d;
  logic        bit_edge;
  logic        bit_val;

  logic [3:0]  state;
  logic [5:0]  ones_cnt;
  logic [4:0]  cnt;
  logic        is_rd;
  logic        op_hi;
  logic [4:0]  phy_sr;
  logic [4:0]  reg_sr;
  logic [15:0] sh;
  logic        rd_cap;

  // Synchronisers run through reset so no false edge appears on release.
  always_ff @(posedge clk) begin
    mdc_s <= {mdc_s[0], mdc};
    mdi_s <= {mdi_s[0], mdio_in};
    mdc_d <= mdc_s[1];
  end

  assign bit_edge = mdc_s[1] & ~mdc_d;
  assign bit_val  = mdi_s[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      ones_cnt       <= '0;
      cnt            <= '0;
      is_rd          <= 1'b0;
      op_hi          <= 1'b0;
      phy_sr         <= '0;
      reg_sr         <= '0;
      sh             <= '0;
      rd_cap         <= 1'b0;
      mdio_out       <= 1'b0;
      mdio_oen       <= 1'b1;
      frame_err      <= 1'b0;
      regs.reg_addr  <= '0;
      regs.reg_rd_en <= 1'b0;
      regs.reg_wr_en <= 1'b0;
      regs.reg_wdata <= '0;
    end else begin
      regs.reg_rd_en <= 1'b0;
      regs.reg_wr_en <= 1'b0;
      frame_err      <= 1'b0;
      // Read data is sampled once, the clk after the strobe.
      rd_cap <= regs.reg_rd_en;
      if (rd_cap) sh <= regs.reg_rdata;
      if (bit_edge) begin
        unique case (state)
          IDLE: begin
            if (bit_val) begin
              if (ones_cnt != PRE) ones_cnt <= ones_cnt + 6'd1;
            end else if (ones_cnt == PRE) begin
              ones_cnt <= '0;
              state    <= ST1;
            end else begin
              ones_cnt <= '0;
            end
          end
          ST1: begin
            cnt   <= '0;
            state <= bit_val ? OP : IDLE;
          end
          OP: begin
            if (cnt == 5'd0) begin
              op_hi <= bit_val;
              cnt   <= 5'd1;
            end else begin
              cnt <= '0;
              if (op_hi != bit_val) begin
                is_rd <= op_hi;
                state <= PHYAD;
              end else begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end
          end
          PHYAD: begin
            phy_sr <= {phy_sr[3:0], bit_val};
            if (cnt == 5'd4) begin
              cnt   <= '0;
              state <= REGAD;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          REGAD: begin
            reg_sr <= {reg_sr[3:0], bit_val};
            if (cnt == 5'd4) begin
              cnt <= '0;
              if (phy_sr == PHY_ADDR) begin
                regs.reg_addr  <= {reg_sr[3:0], bit_val};
                regs.reg_rd_en <= is_rd;
                state          <= is_rd ? TA_RD : TA_WR;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          TA_RD: begin
            mdio_oen <= 1'b0;
            mdio_out <= 1'b0;
            cnt      <= '0;
            state    <= RDATA;
          end
          RDATA: begin
            if (cnt == 5'd16) begin
              mdio_oen <= 1'b1;
              mdio_out <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              mdio_out <= sh[15];
              sh       <= {sh[14:0], 1'b0};
              cnt      <= cnt + 5'd1;
            end
          end
          TA_WR: begin
            if (cnt == 5'd0) begin
              if (bit_val) begin
                cnt <= 5'd1;
              end else begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end else begin
              cnt <= '0;
              if (!bit_val) begin
                state <= WDATA;
              end else begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end
          end
          WDATA: begin
            sh <= {sh[14:0], bit_val};
            if (cnt == 5'd15) begin
              regs.reg_wdata <= {sh[14:0], bit_val};
              regs.reg_wr_en <= 1'b1;
              cnt            <= '0;
              state          <= IDLE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: drives MDC/MDIO frames as the master
// and checks strobes, turnaround drive and read data.
module tb_mdio_phy_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mdc = 1'b0;
  logic mdio_m = 1'b1;
  logic mdio_line;
  logic mdio_out;
  logic mdio_oen;
  logic frame_err;

  mdio_phy_responder_if rif ();

  assign mdio_line = mdio_oen ? mdio_m : mdio_out;

  mdio_phy_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mdc       (mdc),
    .mdio_in   (mdio_line),
    .mdio_out  (mdio_out),
    .mdio_oen  (mdio_oen),
    .frame_err (frame_err),
    .regs      (rif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, oen_low = 0, both = 0;
  int cur_bit = -1;
  int err_bit = -9;
  logic [4:0]  raddr = '0, waddr = '0;
  logic [15:0] wdata = '0;

  int s_rd, s_wr, s_err, s_oen;

  logic obs_oen [0:31];
  logic obs_out [0:31];

  always @(negedge clk) begin
    if (rif.reg_rd_en) begin
      rd_cnt++;
      raddr = rif.reg_addr;
    end
    if (rif.reg_wr_en) begin
      wr_cnt++;
      waddr = rif.reg_addr;
      wdata = rif.reg_wdata;
    end
    if (rif.reg_rd_en && rif.reg_wr_en) both++;
    if (frame_err) begin
      err_cnt++;
      err_bit = cur_bit;
    end
    if (!mdio_oen) oen_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rd  = rd_cnt;
    s_wr  = wr_cnt;
    s_err = err_cnt;
    s_oen = oen_low;
  endtask

  task automatic send_bit(input logic b);
    mdio_m = b;
    #80 mdc = 1'b1;
    #80 mdc = 1'b0;
  endtask

  // Frame body bit i: 0-1 ST, 2-3 OP, 4-8 PHYAD, 9-13 REGAD (E0 = 13), 14.. TA/data.
  task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] d,
                       input int rst_e, input int chg_e);
    logic [31:0] body;
    body = {2'b01, op, phy, rg, ta, d};
    cur_bit = -1;
    send_bit(1'b0);
    for (int i = 0; i < npre; i++) send_bit(1'b1);
    for (int i = 0; i < 32; i++) begin
      cur_bit = i;
      mdio_m = body[31-i];
      #80 mdc = 1'b1;
      #70;
      obs_oen[i] = mdio_oen;
      obs_out[i] = mdio_out;
      if (i == 13 + chg_e) rif.reg_rdata = 16'h0000;
      if (i == 13 + rst_e) begin
        chk("oen_before_rst", {31'd0, mdio_oen}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("oen_after_rst", {31'd0, mdio_oen}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
      end
      #10 mdc = 1'b0;
    end
    cur_bit = -1;
    mdio_m = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  function automatic logic [31:0] oen_pat();
    logic [18:0] p;
    for (int k = 0; k < 19; k++) p[18-k] = obs_oen[13+k];
    return {13'd0, p};
  endfunction

  function automatic logic [31:0] out_pat();
    logic [16:0] q;
    for (int k = 1; k < 18; k++) q[17-k] = obs_out[13+k];
    return {15'd0, q};
  endfunction

  initial begin
    rif.reg_rdata = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_oen", {31'd0, mdio_oen}, 32'd1);
    chk("rst_out", {31'd0, mdio_out}, 32'd0);
    chk("rst_rd_en", {31'd0, rif.reg_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, rif.reg_wr_en}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_addr", {27'd0, rif.reg_addr}, 32'd0);
    chk("rst_wdata", {16'd0, rif.reg_wdata}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    snap();
    frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5C3, -100, -100);
    chk("wr_cnt", wr_cnt - s_wr, 1);
    chk("wr_rd_cnt", rd_cnt - s_rd, 0);
    chk("wr_addr", {27'd0, waddr}, 32'd4);
    chk("wr_data", {16'd0, wdata}, 32'h0000A5C3);
    chk("wr_oen_low", oen_low - s_oen, 0);
    chk("wr_err", err_cnt - s_err, 0);

    snap();
    rif.reg_rdata = 16'h0141;
    frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF, -100, -100);
    chk("rd_cnt", rd_cnt - s_rd, 1);
    chk("rd_wr_cnt", wr_cnt - s_wr, 0);
    chk("rd_addr", {27'd0, raddr}, 32'd2);
    chk("rd_oen_pat", oen_pat(), 32'h00040001);
    chk("rd_data_pat", out_pat(), 32'h00000141);
    chk("rd_err", err_cnt - s_err, 0);

    snap();
    frame(32, 2'b10, 5'd3, 5'd2, 2'b11, 16'hFFFF, -100, -100);
    chk("other_rd_cnt", rd_cnt - s_rd, 0);
    chk("other_wr_cnt", wr_cnt - s_wr, 0);
    chk("other_oen_low", oen_low - s_oen, 0);
    chk("other_err", err_cnt - s_err, 0);

    snap();
    frame(31, 2'b01, 5'd1, 5'd4, 2'b10, 16'h5A3C, -100, -100);
    chk("pre31_wr_cnt", wr_cnt - s_wr, 0);
    chk("pre31_err", err_cnt - s_err, 0);

    snap();
    frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h5A3C, -100, -100);
    chk("pre32_wr_cnt", wr_cnt - s_wr, 1);
    chk("pre32_data", {16'd0, wdata}, 32'h00005A3C);

    snap();
    frame(32, 2'b01, 5'd1, 5'd4, 2'b11, 16'h1234, -100, -100);
    chk("ta11_err", err_cnt - s_err, 1);
    chk("ta11_wr_cnt", wr_cnt - s_wr, 0);

    snap();
    frame(32, 2'b11, 5'd1, 5'd4, 2'b10, 16'h1234, -100, -100);
    chk("op11_err", err_cnt - s_err, 1);
    chk("op11_err_bit", err_bit, 3);
    chk("op11_wr_cnt", wr_cnt - s_wr, 0);

    rif.reg_rdata = 16'h0141;
    frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF, 8, -100);

    snap();
    rif.reg_rdata = 16'h8001;
    frame(32, 2'b10, 5'd1, 5'd31, 2'b11, 16'hFFFF, -100, 4);
    chk("post_rst_rd_cnt", rd_cnt - s_rd, 1);
    chk("post_rst_addr", {27'd0, raddr}, 32'd31);
    chk("post_rst_oen_pat", oen_pat(), 32'h00040001);
    chk("post_rst_data", out_pat(), 32'h00008001);

    chk("never_both", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
